// File: rtl/nand_pipe_pkg.sv
// nand_pipe_pkg: shared constants, FSM states and sizing helper for the nand result pipeline
package nand_pipe_pkg;
  localparam int DEF_WIDTH = 8;
  typedef enum logic {FILL, HOLD} state_t;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/nand_result_packer_if.sv
// nand_result_packer_if: bit stream in, word handshake out; NAND_PACKER_PARITY_EN adds word_parity
interface nand_result_packer_if #(parameter int WIDTH = 8);
  logic en_in;
  logic bit_in;
  logic [WIDTH-1:0] word_out;
  logic word_valid;
  logic word_ready;
  logic overrun;
  logic ovr_clr;
`ifdef NAND_PACKER_PARITY_EN
  logic word_parity;
`endif
  modport slave (input en_in, bit_in, word_ready, ovr_clr, output word_out, word_valid, overrun
`ifdef NAND_PACKER_PARITY_EN
    , output word_parity
`endif
  );
  modport master (output en_in, bit_in, word_ready, ovr_clr, input word_out, word_valid, overrun
`ifdef NAND_PACKER_PARITY_EN
    , input word_parity
`endif
  );
endinterface

// File: rtl/packer_out_slot.sv
// packer_out_slot: one-word output register with valid/ready; NAND_PACKER_PARITY_EN adds parity
module packer_out_slot import nand_pipe_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic [WIDTH-1:0] word,
  input  logic ready,
  output logic [WIDTH-1:0] word_out,
  output logic word_valid,
  output logic free
`ifdef NAND_PACKER_PARITY_EN
  , output logic word_parity
`endif
);
  assign free = !word_valid || ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      word_out <= '0;
      word_valid <= 1'b0;
    end else if (load) begin
      word_out <= word;
      word_valid <= 1'b1;
    end else if (ready) word_valid <= 1'b0;
  end
`ifdef NAND_PACKER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) word_parity <= 1'b0;
    else if (load) word_parity <= ^word;
  end
`endif
endmodule

// File: rtl/nand_result_packer.sv
// nand_result_packer: LSB-first bit collector into WIDTH-bit words; NAND_PACKER_PARITY_EN adds word_parity
module nand_result_packer import nand_pipe_pkg::*; #(parameter int WIDTH = DEF_WIDTH) (
  input logic clk,
  input logic rst,
  nand_result_packer_if.slave p
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] sr, sr_n, word, shifted;
  logic [CW-1:0] cnt, cnt_n;
  logic load, drop, free, ovr_n;
  assign shifted = {p.bit_in, sr[WIDTH-1:1]};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      sr <= '0;
      cnt <= '0;
      p.overrun <= 1'b0;
    end else begin
      state <= state_n;
      sr <= sr_n;
      cnt <= cnt_n;
      p.overrun <= ovr_n;
    end
  end
  // in HOLD sr already holds the finished word; a drain frees it and may accept a new first bit
  always_comb begin
    state_n = state;
    sr_n = sr;
    cnt_n = cnt;
    load = 1'b0;
    word = sr;
    drop = 1'b0;
    if (state == FILL) begin
      if (p.en_in) begin
        sr_n = shifted;
        if (cnt == LAST) begin
          load = free;
          word = shifted;
          cnt_n = free ? '0 : FULL;
          state_n = free ? FILL : HOLD;
        end else cnt_n = cnt + CW'(1);
      end
    end else if (p.word_valid && p.word_ready) begin
      load = 1'b1;
      state_n = FILL;
      sr_n = p.en_in ? shifted : sr;
      cnt_n = p.en_in ? CW'(1) : '0;
    end else drop = p.en_in;
    ovr_n = drop || (p.overrun && !p.ovr_clr);
  end
  packer_out_slot #(.WIDTH(WIDTH)) u_slot (
    .clk(clk),
    .rst(rst),
    .load(load),
    .word(word),
    .ready(p.word_ready),
    .word_out(p.word_out),
    .word_valid(p.word_valid),
    .free(free)
`ifdef NAND_PACKER_PARITY_EN
    , .word_parity(p.word_parity)
`endif
  );
endmodule

// File: tb/tb_nand_result_packer.sv
// tb_nand_result_packer: directed scoreboard bench; parity checks when NAND_PACKER_PARITY_EN is defined
module tb_nand_result_packer;
  import nand_pipe_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  nand_result_packer_if #(.WIDTH(8)) bus ();
  nand_result_packer #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .p(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      bus.en_in = 1'b0;
      bus.bit_in = ~b;
      tick();
    end
    bus.en_in = 1'b1;
    bus.bit_in = b;
    tick();
    bus.en_in = 1'b0;
    bus.bit_in = 1'($urandom);
  endtask
  task automatic send_word(input logic [7:0] w, input int maxgap);
    for (int i = 0; i < 8; i++) send_bit(w[i], maxgap == 0 ? 0 : int'($urandom_range(maxgap, 1)));
    exp_q.push_back(w);
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask
  always @(negedge clk) begin
    if (!rst && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_word", {24'h0, bus.word_out}, 32'hffff_ffff);
      else begin
        chk("word_out", {24'h0, bus.word_out}, {24'h0, exp_q[0]});
`ifdef NAND_PACKER_PARITY_EN
        chk("word_parity", {31'h0, bus.word_parity}, {31'h0, ^exp_q[0]});
`endif
        void'(exp_q.pop_front());
      end
    end
  end
  initial begin
    logic [7:0] w1;
    bus.en_in = 1'b0;
    bus.bit_in = 1'b0;
    bus.word_ready = 1'b0;
    bus.ovr_clr = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      bus.en_in = 1'($urandom);
      bus.bit_in = 1'($urandom);
      bus.word_ready = 1'($urandom);
      bus.ovr_clr = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    bus.en_in = 1'b0;
    bus.ovr_clr = 1'b0;
    bus.word_ready = 1'b1;
    @(negedge clk);
    chk("rst_word_out", {24'h0, bus.word_out}, 32'h0);
    chk("rst_word_valid", {31'h0, bus.word_valid}, 32'h0);
    chk("rst_overrun", {31'h0, bus.overrun}, 32'h0);
    w1 = 8'h4d;
    for (int i = 0; i < 7; i++) begin
      send_bit(w1[i], 0);
      @(negedge clk);
      chk("early_valid", {31'h0, bus.word_valid}, 32'h0);
    end
    send_bit(w1[7], 0);
    exp_q.push_back(w1);
    @(negedge clk);
    chk("pulse_valid_hi", {31'h0, bus.word_valid}, 32'h1);
    chk("pulse_word", {24'h0, bus.word_out}, 32'h4d);
    @(negedge clk);
    chk("pulse_valid_lo", {31'h0, bus.word_valid}, 32'h0);
    #1;
    send_word(8'h4d, 3);
    send_word(8'h4c, 2);
    repeat (3) tick();
    chk("queue_drained_1", exp_q.size(), 0);
    bus.word_ready = 1'b0;
    send_word(8'h4d, 0);
    send_word(8'hff, 0);
    chk("hold_state", {31'h0, dut.state}, {31'h0, HOLD});
    chk("hold_no_ovr", {31'h0, bus.overrun}, 32'h0);
    send_bit(1'b1, 0);
    chk("ovr_set", {31'h0, bus.overrun}, 32'h1);
    repeat (3) tick();
    chk("stall_word", {24'h0, bus.word_out}, 32'h4d);
    chk("stall_valid", {31'h0, bus.word_valid}, 32'h1);
`ifdef NAND_PACKER_PARITY_EN
    chk("stall_parity", {31'h0, bus.word_parity}, 32'h0);
`endif
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
    @(negedge clk);
    chk("after_drain_word", {24'h0, bus.word_out}, 32'hff);
    chk("after_drain_valid", {31'h0, bus.word_valid}, 32'h1);
    chk("after_drain_state", {31'h0, dut.state}, {31'h0, FILL});
    chk("ovr_sticky", {31'h0, bus.overrun}, 32'h1);
    #1;
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    chk("ovr_clr", {31'h0, bus.overrun}, 32'h0);
    bus.word_ready = 1'b1;
    tick();
    bus.word_ready = 1'b0;
    send_word(8'h4d, 0);
    send_word(8'h3c, 0);
    bus.word_ready = 1'b1;
    send_word(8'h81, 0);
    repeat (3) tick();
    chk("drain_accept_queue", exp_q.size(), 0);
    chk("drain_accept_ovr", {31'h0, bus.overrun}, 32'h0);
    bus.word_ready = 1'b0;
    send_word(8'h11, 0);
    send_word(8'h22, 0);
    send_bit(1'b0, 0);
    bus.ovr_clr = 1'b1;
    send_bit(1'b1, 0);
    bus.ovr_clr = 1'b0;
    chk("drop_beats_clr", {31'h0, bus.overrun}, 32'h1);
    bus.word_ready = 1'b1;
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 0);
    pulse_rst();
    chk("rst2_valid", {31'h0, bus.word_valid}, 32'h0);
    send_word(8'ha5, 0);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
